// File: rtl/line_buf_arb_pkg.sv
// line_buf_arb_pkg
//   Shared definitions for the line-buffer arbiter:
//   - state_t      : FSM encoding (SYNC=0, WAIT=1, CAPT=2, SWAP=3)
//   - DEF_ADDR_WIDTH / DEF_CNT_WIDTH : default parameter values for the top
package line_buf_arb_pkg;

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,  // waiting for the first iFVAL=0 after reset
    ST_WAIT = 2'd1,  // between frames
    ST_CAPT = 2'd2,  // capturing a frame, writes accepted
    ST_SWAP = 2'd3   // one-cycle frame-end decision
  } state_t;

  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_CNT_WIDTH  = 16;

endpackage

// File: rtl/fval_edge_det.sv
// fval_edge_det
//   Rise/fall detector for the (already synchronous) camera frame-valid.
//   Ports:
//     clk     in  : camera clock
//     srst    in  : synchronous active-high reset
//     fval_i  in  : frame valid
//     rise_o  out : fval_i is 1 this cycle and was 0 last cycle
//     fall_o  out : fval_i is 0 this cycle and was 1 last cycle
module fval_edge_det (
  input  logic clk,
  input  logic srst,
  input  logic fval_i,
  output logic rise_o,
  output logic fall_o
);

  logic fval_q;
  logic fval_d;

  always_comb begin
    fval_d = fval_i;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      fval_q <= 1'b0;
    end else begin
      fval_q <= fval_d;
    end
  end

  assign rise_o = fval_i & ~fval_q;
  assign fall_o = ~fval_i & fval_q;

endmodule

// File: rtl/line_buf_arb.sv
// line_buf_arb
//   Ping-pong line-memory arbiter between a camera line writer and a
//   centroid reader. Two banks (A/B) share one port-A address; the writer
//   owns bank oWBANK, the reader the other one. Writes always win.
//   Optional statistics counters are compiled only when the macro
//   LINE_BUF_ARB_STATS_EN is defined; otherwise they are tied to 0.
//   Ports:
//     CLK, RST                  : clock, synchronous active-high reset
//     iFVAL                     : camera frame valid
//     iWR_REQ, iWR_ADDR         : writer strobe / row address
//     iRD_REQ, iRD_ADDR         : reader strobe / row address
//     iRD_BUSY                  : reader is scanning its bank
//     oRD_GNT                   : read accepted this cycle (combinational)
//     oRD_VALID                 : read data valid (2 cycles after grant)
//     oADDR, oEN_A/B, oWE_A/B   : registered memory port-A controls
//     oWBANK                    : current write bank (0=A, 1=B)
//     oFRAME_DONE, oOVERRUN     : single-cycle frame-end status pulses
//     oOVR_CNT, oSTALL_CNT      : saturating statistics counters
module line_buf_arb
  import line_buf_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  iFVAL,
  input  logic                  iWR_REQ,
  input  logic [ADDR_WIDTH-1:0] iWR_ADDR,
  input  logic                  iRD_REQ,
  input  logic [ADDR_WIDTH-1:0] iRD_ADDR,
  input  logic                  iRD_BUSY,
  output logic                  oRD_GNT,
  output logic                  oRD_VALID,
  output logic [ADDR_WIDTH-1:0] oADDR,
  output logic                  oEN_A,
  output logic                  oEN_B,
  output logic                  oWE_A,
  output logic                  oWE_B,
  output logic                  oWBANK,
  output logic                  oFRAME_DONE,
  output logic                  oOVERRUN,
  output logic [CNT_WIDTH-1:0]  oOVR_CNT,
  output logic [CNT_WIDTH-1:0]  oSTALL_CNT
);

  state_t state_q, state_d;

  logic                  fval_rise;
  logic                  fval_fall;
  logic                  wr_acc;
  logic                  rd_gnt;
  logic                  swap_ok;
  logic                  swap_ovr;

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  en_a_q, en_a_d;
  logic                  en_b_q, en_b_d;
  logic                  we_a_q, we_a_d;
  logic                  we_b_q, we_b_d;
  logic                  wbank_q, wbank_d;
  logic                  frame_done_q, frame_done_d;
  logic                  overrun_q, overrun_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  rd_valid_q, rd_valid_d;

  fval_edge_det u_fval_edge (
    .clk    (CLK),
    .srst   (RST),
    .fval_i (iFVAL),
    .rise_o (fval_rise),
    .fall_o (fval_fall)
  );

  // WAIT is only entered with iFVAL low and SWAP is only entered on a fall,
  // so a high iFVAL in WAIT/SWAP is always a rising edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SYNC: if (!iFVAL)    state_d = ST_WAIT;
      ST_WAIT: if (fval_rise) state_d = ST_CAPT;
      ST_CAPT: if (fval_fall) state_d = ST_SWAP;
      ST_SWAP: state_d = fval_rise ? ST_CAPT : ST_WAIT;
      default: state_d = ST_SYNC;
    endcase
  end

  assign wr_acc   = (state_q == ST_CAPT) && iWR_REQ;
  assign rd_gnt   = iRD_REQ && !wr_acc && !RST;
  assign swap_ok  = (state_q == ST_SWAP) && !iRD_BUSY;
  assign swap_ovr = (state_q == ST_SWAP) && iRD_BUSY;

  // Bank selection uses wbank_q of the access cycle, so a toggle landing
  // in the following cycle never redirects an access already issued.
  always_comb begin
    addr_d       = addr_q;
    en_a_d       = 1'b0;
    en_b_d       = 1'b0;
    we_a_d       = 1'b0;
    we_b_d       = 1'b0;
    wbank_d      = wbank_q ^ swap_ok;
    frame_done_d = swap_ok;
    overrun_d    = swap_ovr;
    rd_pend_d    = rd_gnt;
    rd_valid_d   = rd_pend_q;
    if (wr_acc) begin
      addr_d = iWR_ADDR;
      if (wbank_q) begin
        en_b_d = 1'b1;
        we_b_d = 1'b1;
      end else begin
        en_a_d = 1'b1;
        we_a_d = 1'b1;
      end
    end else if (rd_gnt) begin
      addr_d = iRD_ADDR;
      if (wbank_q) begin
        en_a_d = 1'b1;
      end else begin
        en_b_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_SYNC;
      addr_q       <= '0;
      en_a_q       <= 1'b0;
      en_b_q       <= 1'b0;
      we_a_q       <= 1'b0;
      we_b_q       <= 1'b0;
      wbank_q      <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      rd_pend_q    <= 1'b0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      en_a_q       <= en_a_d;
      en_b_q       <= en_b_d;
      we_a_q       <= we_a_d;
      we_b_q       <= we_b_d;
      wbank_q      <= wbank_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
      rd_pend_q    <= rd_pend_d;
      rd_valid_q   <= rd_valid_d;
    end
  end

  assign oRD_GNT     = rd_gnt;
  assign oRD_VALID   = rd_valid_q;
  assign oADDR       = addr_q;
  assign oEN_A       = en_a_q;
  assign oEN_B       = en_b_q;
  assign oWE_A       = we_a_q;
  assign oWE_B       = we_b_q;
  assign oWBANK      = wbank_q;
  assign oFRAME_DONE = frame_done_q;
  assign oOVERRUN    = overrun_q;

`ifdef LINE_BUF_ARB_STATS_EN
  logic [CNT_WIDTH-1:0] ovr_cnt_q, ovr_cnt_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  // The overrun count steps on the same edge that raises oOVERRUN.
  always_comb begin
    ovr_cnt_d   = ovr_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (swap_ovr && (ovr_cnt_q != '1)) begin
      ovr_cnt_d = ovr_cnt_q + CNT_WIDTH'(1);
    end
    if (iRD_REQ && !rd_gnt && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ovr_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      ovr_cnt_q   <= ovr_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign oOVR_CNT   = ovr_cnt_q;
  assign oSTALL_CNT = stall_cnt_q;
`else
  assign oOVR_CNT   = '0;
  assign oSTALL_CNT = '0;
`endif

endmodule

// File: doc/line_buf_arb.md
LINE_BUF_ARB -- requirements
Module: line_buf_arb

Interface
REQ-001 Parameter ADDR_WIDTH, default 10: line-memory row address width.
REQ-002 Parameter CNT_WIDTH, default 16: width of the statistics counters.
REQ-003 Ports CLK in 1 (camera clock) and RST in 1; one clock; reset is synchronous and active-high.
REQ-004 Port iFVAL in 1: camera frame valid, already synchronous to CLK.
REQ-005 Ports iWR_REQ in 1 and iWR_ADDR in ADDR_WIDTH: line-writer strobe and row address.
REQ-006 Ports iRD_REQ in 1, iRD_ADDR in ADDR_WIDTH and iRD_BUSY in 1: centroid-reader strobe, row address, and scan-in-progress flag.
REQ-007 Port oRD_GNT out 1: read accepted this cycle.
REQ-008 Port oRD_VALID out 1: read data valid on the memory output.
REQ-009 Port oADDR out ADDR_WIDTH: shared port-A address to both banks.
REQ-010 Ports oEN_A, oEN_B, oWE_A and oWE_B, each out 1: port-A enable and write enable per bank.
REQ-011 Port oWBANK out 1: current write bank, 0=A and 1=B.
REQ-012 Ports oFRAME_DONE out 1 and oOVERRUN out 1: single-cycle status pulses.
REQ-013 Ports oOVR_CNT out CNT_WIDTH and oSTALL_CNT out CNT_WIDTH: statistics counters.

Function
REQ-014 The block shall keep a four-state FSM: SYNC, WAIT, CAPT, SWAP.
REQ-015 Leaving reset, the FSM shall enter SYNC and go to WAIT on the first cycle iFVAL=0, so a partial frame is never captured.
REQ-016 In WAIT, iFVAL=1 shall move the FSM to CAPT.
REQ-017 In CAPT, iFVAL=0 (falling edge) shall move the FSM to SWAP.
REQ-018 SWAP shall last one cycle and then go to WAIT, or to CAPT if iFVAL=1 that cycle.
REQ-019 In SWAP with iRD_BUSY=0: toggle oWBANK the next cycle, pulse oFRAME_DONE for 1 cycle.
REQ-020 In SWAP with iRD_BUSY=1: oWBANK unchanged, pulse oOVERRUN for 1 cycle, frame discarded (the next frame overwrites the same bank).
REQ-021 Write acceptance: a write shall be accepted only in CAPT with iWR_REQ=1; in any other state iWR_REQ is ignored, with no memory access.
REQ-022 Priority: an accepted write always wins; oRD_GNT = iRD_REQ AND NOT (accepted write), combinational, same cycle.
REQ-023 A refused read shall not be queued; the reader holds iRD_REQ until oRD_GNT.
REQ-024 Latency: an accepted access in cycle n shall appear as registered oADDR/oEN/oWE in cycle n+1.
REQ-025 A granted read shall raise oRD_VALID in cycle n+2, matching the 1-cycle memory read latency.
REQ-026 A write shall drive oADDR=iWR_ADDR, oEN and oWE of bank oWBANK, and both signals of the other bank low.
REQ-027 A read shall drive oADDR=iRD_ADDR, oEN of bank NOT oWBANK, and oWE low on both banks.
REQ-028 With no access, all oEN/oWE shall be 0 and oADDR shall hold its value.
REQ-029 oEN_A and oEN_B shall never both be 1 in the same cycle.
REQ-030 Bank toggle versus access: the bank in effect is the one latched in the access cycle n, even if oWBANK toggles at n+1.

Reset
REQ-031 RST=1 at any CLK edge, including mid-frame or mid-read, shall set state SYNC, oWBANK=0, oADDR=0, all oEN/oWE=0, oRD_VALID=0 and all pulses=0.
REQ-032 The same reset shall clear the counters to 0.
REQ-033 oRD_GNT shall be 0 while RST=1.
REQ-034 An in-flight read shall be dropped by reset, with no oRD_VALID.

Configuration
REQ-035 With macro LINE_BUF_ARB_STATS_EN defined: oOVR_CNT increments on each oOVERRUN, and oSTALL_CNT increments on each cycle iRD_REQ=1 AND oRD_GNT=0.
REQ-036 With LINE_BUF_ARB_STATS_EN defined, both counters saturate at all-ones.
REQ-037 With LINE_BUF_ARB_STATS_EN undefined, oOVR_CNT and oSTALL_CNT shall be tied to 0 and no counter logic shall be compiled.

Structure
REQ-038 Package line_buf_arb_pkg shall hold the FSM state encoding (SYNC=0, WAIT=1, CAPT=2, SWAP=3) and the default ADDR_WIDTH/CNT_WIDTH constants.
REQ-039 The iFVAL rise/fall detection shall be one sub-module, fval_edge_det.

Verification
REQ-040 Reset while iFVAL=1, then release -> FSM stays SYNC until iFVAL=0; writes during that partial frame produce no oWE.
REQ-041 Capture: 480 writes (rows 0..479) in CAPT, then iFVAL falls with iRD_BUSY=0 -> oWE_A pulses 480 times, oFRAME_DONE for 1 cycle, oWBANK 0->1.
REQ-042 Collision: iWR_REQ=1 and iRD_REQ=1 (rd addr 0x005) in the same cycle -> oRD_GNT=0, write to bank A; next free cycle oRD_GNT=1; bank-B read at addr 0x005 with oRD_VALID two cycles after grant.
REQ-043 Overrun: iRD_BUSY=1 at frame end -> oOVERRUN for 1 cycle, oWBANK unchanged, oOVR_CNT 0->1 with LINE_BUF_ARB_STATS_EN; next frame rewrites the same bank.
REQ-044 Stall count: iRD_REQ held for 3 cycles against continuous writes -> oSTALL_CNT=3 with LINE_BUF_ARB_STATS_EN, =0 without.
REQ-045 RST pulsed one cycle after a read grant -> no oRD_VALID, oWBANK=0, counters=0.
